// File: rtl/comparador_8_bit.sv
// comparador_8_bit: byte-wide equality comparator.
// The equality flag `igual` is purely combinational and ignores clk/rst_n.
// A one-stage registered side channel provides the XOR difference, its
// popcount and a saturating count of cycles on which the operands matched.
module comparador_8_bit #(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    output logic             igual,
    input  logic [W-1:0]     A,
    input  logic [W-1:0]     B,
    input  logic             clk,
    input  logic             rst_n,
    output logic             igual_r,
    output logic [W-1:0]     diff_r,
    output logic [3:0]       ndiff_r,
    output logic [CNT_W-1:0] match_cnt
);

    logic [W-1:0] e;
    logic [W-1:0] diff;
    logic [1:0]   sum2 [4];
    logic [2:0]   sum3 [2];
    logic [3:0]   ndiff;

    // Per-bit equality, then a 3-level AND tree down to the single flag.
    always_comb begin
        e     = ~(A ^ B);
        igual = ((e[0] & e[1]) & (e[2] & e[3])) & ((e[4] & e[5]) & (e[6] & e[7]));
    end

    // Bitwise difference and its popcount as a 2-bit / 3-bit / 4-bit adder tree.
    always_comb begin
        diff = A ^ B;
        for (int i = 0; i < 4; i++) begin
            sum2[i] = {1'b0, diff[2*i]} + {1'b0, diff[2*i+1]};
        end
        for (int j = 0; j < 2; j++) begin
            sum3[j] = {1'b0, sum2[2*j]} + {1'b0, sum2[2*j+1]};
        end
        ndiff = {1'b0, sum3[0]} + {1'b0, sum3[1]};
    end

    // Registered side channel; the match counter saturates instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            igual_r   <= 1'b0;
            diff_r    <= '0;
            ndiff_r   <= 4'd0;
            match_cnt <= '0;
        end else begin
            igual_r <= igual;
            diff_r  <= diff;
            ndiff_r <= ndiff;
            if (igual && (match_cnt != {CNT_W{1'b1}})) begin
                match_cnt <= match_cnt + 1'b1;
            end
        end
    end

    // The flag and the popcount are built independently; they must agree.
    a_igual_vs_ndiff : assert property (@(posedge clk) igual == (ndiff == 4'd0));

endmodule

// File: tb/tb_comparador_8_bit.sv
module tb_comparador_8_bit;

    logic        igual;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        clk;
    logic        rst_n;
    logic        igual_r;
    logic [7:0]  diff_r;
    logic [3:0]  ndiff_r;
    logic [15:0] match_cnt;

    logic        clk_en;
    int          n_cmp;
    int          n_err;

    comparador_8_bit dut (
        .igual     (igual),
        .A         (A),
        .B         (B),
        .clk       (clk),
        .rst_n     (rst_n),
        .igual_r   (igual_r),
        .diff_r    (diff_r),
        .ndiff_r   (ndiff_r),
        .match_cnt (match_cnt)
    );

    // Clock only toggles once enabled, so the first checks run with no edges.
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        n_cmp  = 0;
        n_err  = 0;
        clk    = 1'b0;
        clk_en = 1'b0;
        rst_n  = 1'b0;
        A      = 8'h04;
        B      = 8'h04;

        // Combinational path with no clock activity, registers held in reset.
        #10;
        chk("eq_noclk", {31'd0, igual}, 32'd1);
        chk("rst_igual_r", {31'd0, igual_r}, 32'd0);
        chk("rst_diff_r", {24'd0, diff_r}, 32'h00);
        chk("rst_ndiff_r", {28'd0, ndiff_r}, 32'd0);
        chk("rst_match_cnt", {16'd0, match_cnt}, 32'd0);

        A = 8'h14;
        B = 8'h24;
        #1;
        chk("ne_14_24", {31'd0, igual}, 32'd0);

        clk_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("diff_14_24", {24'd0, diff_r}, 32'h30);
        chk("ndiff_14_24", {28'd0, ndiff_r}, 32'd2);
        chk("igual_r_14_24", {31'd0, igual_r}, 32'd0);
        chk("cnt_after_ne", {16'd0, match_cnt}, 32'd0);

        @(negedge clk);
        A = 8'h84;
        B = 8'h44;
        #1;
        chk("ne_84_44", {31'd0, igual}, 32'd0);
        tick();
        chk("diff_84_44", {24'd0, diff_r}, 32'hC0);
        chk("ndiff_84_44", {28'd0, ndiff_r}, 32'd2);

        @(negedge clk);
        A = 8'h00;
        B = 8'hFF;
        tick();
        chk("ndiff_00_ff", {28'd0, ndiff_r}, 32'd8);
        chk("diff_00_ff", {24'd0, diff_r}, 32'hFF);

        // Fresh reset, then five matching edges.
        @(negedge clk);
        A     = 8'h04;
        B     = 8'h04;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("cnt_5", {16'd0, match_cnt}, 32'd5);
        chk("igual_r_eq", {31'd0, igual_r}, 32'd1);
        chk("ndiff_eq", {28'd0, ndiff_r}, 32'd0);

        // Asynchronous reset between edges.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_igual_r", {31'd0, igual_r}, 32'd0);
        chk("arst_diff_r", {24'd0, diff_r}, 32'h00);
        chk("arst_ndiff_r", {28'd0, ndiff_r}, 32'd0);
        chk("arst_match_cnt", {16'd0, match_cnt}, 32'd0);
        chk("arst_igual", {31'd0, igual}, 32'd1);
        @(posedge clk);
        #1;
        chk("arst_hold", {16'd0, match_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("cnt_after_rel", {16'd0, match_cnt}, 32'd1);

        // Saturation near the top of the counter.
        @(negedge clk);
        force dut.match_cnt = 16'hFFFD;
        #1;
        release dut.match_cnt;
        tick();
        chk("sat_fffe", {16'd0, match_cnt}, 32'hFFFE);
        tick();
        chk("sat_ffff", {16'd0, match_cnt}, 32'hFFFF);
        tick();
        chk("sat_hold1", {16'd0, match_cnt}, 32'hFFFF);
        tick();
        chk("sat_hold2", {16'd0, match_cnt}, 32'hFFFF);

        // Counter holds when operands differ.
        @(negedge clk);
        force dut.match_cnt = 16'h0010;
        #1;
        release dut.match_cnt;
        A = 8'h01;
        B = 8'h03;
        tick();
        chk("cnt_hold_ne", {16'd0, match_cnt}, 32'h0010);

        // Random vectors, every fourth forced equal.
        for (int k = 0; k < 10000; k++) begin
            @(negedge clk);
            ra = 8'($urandom);
            rb = ((k % 4) == 0) ? ra : 8'($urandom);
            A  = ra;
            B  = rb;
            #1;
            chk("rnd_igual", {31'd0, igual}, {31'd0, (ra == rb)});
            tick();
            chk("rnd_igual_r", {31'd0, igual_r}, {31'd0, (ra == rb)});
            chk("rnd_ndiff_r", {28'd0, ndiff_r}, 32'($countones(ra ^ rb)));
            chk("rnd_diff_r", {24'd0, diff_r}, {24'd0, ra ^ rb});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
